// File: rtl/game_click_capture.sv
// game_click_capture: producer side of the minesweeper click handshake.
// Synchronises and debounces the select button, latches the cursor position
// and derived grid cell index on each accepted press, and holds the event
// until the processor acknowledges it with pr_reset.
// Optional build macro FLAG_BUTTON_EN adds a second (flag) button whose
// events set VGAid[31].
module game_click_capture #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned X_ORIGIN        = 64,
    parameter int unsigned Y_ORIGIN        = 48,
    parameter int unsigned CELL_SHIFT_X    = 5,
    parameter int unsigned CELL_SHIFT_Y    = 5,
    parameter int unsigned GRID_COLS       = 16,
    parameter int unsigned GRID_ROWS       = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_raw,
`ifdef FLAG_BUTTON_EN
    input  logic        btn_flag_raw,
`endif
    input  logic [9:0]  cursor_x,
    input  logic [8:0]  cursor_y,
    input  logic        pr_reset,
    output logic        pressed,
    output logic [9:0]  x_game,
    output logic [8:0]  y_game,
    output logic [31:0] VGAid,
    output logic        busy
);

`ifdef FLAG_BUTTON_EN
    localparam int NUM_BTN = 2;
`else
    localparam int NUM_BTN = 1;
`endif
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PENDING      = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_t;

    // Bit 0 is the select button; bit 1 (when present) is the flag button.
    logic [NUM_BTN-1:0] btn_in;
`ifdef FLAG_BUTTON_EN
    assign btn_in = {btn_flag_raw, btn_raw};
`else
    assign btn_in = btn_raw;
`endif

    logic [NUM_BTN-1:0]            sync1_q, sync1_d;
    logic [NUM_BTN-1:0]            sync2_q, sync2_d;
    logic [NUM_BTN-1:0]            db_q, db_d;
    logic [NUM_BTN-1:0]            db_prev_q, db_prev_d;
    logic [NUM_BTN-1:0]            rise_q, rise_d;
    logic [NUM_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [31:0] id_q, id_d;

    logic [10:0] dx, dy;
    logic        borrow_x, borrow_y;
    logic [31:0] col, row;
    logic [31:0] cell_id;

    // Cell index of the live cursor; off-grid positions map to 0x0000FFFF.
    always_comb begin
        dx       = 11'(cursor_x) - 11'(X_ORIGIN);
        dy       = 11'(cursor_y) - 11'(Y_ORIGIN);
        borrow_x = 11'(cursor_x) < 11'(X_ORIGIN);
        borrow_y = 11'(cursor_y) < 11'(Y_ORIGIN);
        col      = 32'(dx >> CELL_SHIFT_X);
        row      = 32'(dy >> CELL_SHIFT_Y);
        cell_id  = 32'h0000_FFFF;
        if (!borrow_x && !borrow_y && (col < GRID_COLS) && (row < GRID_ROWS)) begin
            cell_id = row * GRID_COLS + col;
        end
    end

    // Two-flop synchronisers, debounce counters and the registered rise pulse.
    always_comb begin
        sync1_d   = btn_in;
        sync2_d   = sync1_q;
        db_d      = db_q;
        cnt_d     = cnt_q;
        db_prev_d = db_q;
        rise_d    = db_q & ~db_prev_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                db_d[i]  = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Event FSM: capture on a rise in IDLE, hold until ack, then wait for release.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (|rise_q) begin
                    x_d     = cursor_x;
                    y_d     = cursor_y;
                    id_d    = cell_id;
`ifdef FLAG_BUTTON_EN
                    if (!rise_q[0]) begin
                        id_d[31] = 1'b1;
                    end
`endif
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (pr_reset) begin
                    state_d = (|db_q) ? WAIT_RELEASE : IDLE;
                end
            end
            WAIT_RELEASE: begin
                if (db_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All state registers; reset is asynchronous and active-low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            rise_q    <= '0;
            cnt_q     <= '0;
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            id_q      <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            rise_q    <= rise_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            id_q      <= id_d;
        end
    end

    assign pressed = (state_q == PENDING);
    assign busy    = (state_q != IDLE);
    assign x_game  = x_q;
    assign y_game  = y_q;
    assign VGAid   = id_q;

endmodule

// File: tb/tb_game_click_capture.sv
// tb_game_click_capture: randomized self-checking bench for game_click_capture
// with a short debounce window. Define FLAG_BUTTON_EN to exercise the flag button.
module tb_game_click_capture;

    localparam int D    = 4;
    localparam int X0   = 64;
    localparam int Y0   = 48;
    localparam int CW   = 32;
    localparam int CH   = 32;
    localparam int COLS = 16;
    localparam int ROWS = 12;

    logic        clock = 1'b0;
    logic        reset;
    logic        btn_raw;
`ifdef FLAG_BUTTON_EN
    logic        btn_flag_raw;
`endif
    logic [9:0]  cursor_x;
    logic [8:0]  cursor_y;
    logic        pr_reset;
    logic        pressed;
    logic [9:0]  x_game;
    logic [8:0]  y_game;
    logic [31:0] VGAid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    game_click_capture #(
        .DEBOUNCE_CYCLES(D),
        .X_ORIGIN(X0),
        .Y_ORIGIN(Y0),
        .CELL_SHIFT_X(5),
        .CELL_SHIFT_Y(5),
        .GRID_COLS(COLS),
        .GRID_ROWS(ROWS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .btn_raw(btn_raw),
`ifdef FLAG_BUTTON_EN
        .btn_flag_raw(btn_flag_raw),
`endif
        .cursor_x(cursor_x),
        .cursor_y(cursor_y),
        .pr_reset(pr_reset),
        .pressed(pressed),
        .x_game(x_game),
        .y_game(y_game),
        .VGAid(VGAid),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // Counts one comparison and reports it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input int x, input int y, input logic btn);
        cursor_x = 10'(x);
        cursor_y = 9'(y);
        btn_raw  = btn;
    endtask

    task automatic ackPulse();
        pr_reset = 1'b1;
        tick(1);
        pr_reset = 1'b0;
    endtask

    task automatic waitPressed(input int budget, output int cycles);
        cycles = 0;
        while (!pressed && cycles < budget) begin
            tick(1);
            cycles++;
        end
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
    endtask

    // Reference cell index straight from the grid geometry.
    function automatic logic [31:0] modelId(input int x, input int y);
        int col, row;
        if (x < X0 || y < Y0) return 32'h0000_FFFF;
        col = (x - X0) / CW;
        row = (y - Y0) / CH;
        if (col >= COLS || row >= ROWS) return 32'h0000_FFFF;
        return 32'(row * COLS + col);
    endfunction

    initial begin
        int cyc;
        int ox[2];
        int oy[2];
        logic seen;
        int exp_x, exp_y;
        logic [31:0] exp_id;

        reset    = 1'b0;
        pr_reset = 1'b0;
`ifdef FLAG_BUTTON_EN
        btn_flag_raw = 1'b0;
`endif
        applyStimulus(0, 0, 1'b0);
        tick(3);
        checkOutput("reset_pressed", 32'(pressed), 32'd0);
        checkOutput("reset_x", 32'(x_game), 32'd0);
        checkOutput("reset_y", 32'(y_game), 32'd0);
        checkOutput("reset_id", VGAid, 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        tick(2);

        // Directed press and hold-stability.
        applyStimulus(100, 80, 1'b1);
        waitPressed(20, cyc);
        checkOutput("latency_within_8", 32'(cyc <= 8), 32'd1);
        checkOutput("dir_pressed", 32'(pressed), 32'd1);
        checkOutput("dir_x", 32'(x_game), 32'd100);
        checkOutput("dir_y", 32'(y_game), 32'd80);
        checkOutput("dir_id", VGAid, modelId(100, 80));
        applyStimulus(300, 200, 1'b1);
        tick(5);
        checkOutput("hold_x", 32'(x_game), 32'd100);
        checkOutput("hold_y", 32'(y_game), 32'd80);
        checkOutput("hold_id", VGAid, 32'd17);

        // Second press while pending is dropped.
        applyStimulus(300, 200, 1'b0);
        tick(D + 6);
        applyStimulus(300, 200, 1'b1);
        tick(D + 6);
        checkOutput("second_press_id", VGAid, 32'd17);
        checkOutput("second_press_pressed", 32'(pressed), 32'd1);
        ackPulse();
        checkOutput("ack_pressed", 32'(pressed), 32'd0);
        checkOutput("ack_busy_held", 32'(busy), 32'd1);
        tick(D + 6);
        checkOutput("no_autorepeat", 32'(pressed), 32'd0);
        applyStimulus(300, 200, 1'b0);
        waitIdle(20);
        checkOutput("release_busy", 32'(busy), 32'd0);
        checkOutput("single_event", 32'(pressed), 32'd0);
        checkOutput("retain_x", 32'(x_game), 32'd100);

        // Grid origin.
        applyStimulus(64, 48, 1'b1);
        waitPressed(20, cyc);
        checkOutput("origin_pressed", 32'(pressed), 32'd1);
        checkOutput("origin_id", VGAid, 32'd0);
        applyStimulus(64, 48, 1'b0);
        tick(D + 6);
        ackPulse();
        checkOutput("origin_ack_busy", 32'(busy), 32'd0);

        // Off-grid positions.
        ox[0] = 10;  oy[0] = 10;
        ox[1] = 576; oy[1] = 80;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(ox[i], oy[i], 1'b1);
            waitPressed(20, cyc);
            checkOutput("offgrid_pressed", 32'(pressed), 32'd1);
            checkOutput("offgrid_id", VGAid, 32'h0000_FFFF);
            applyStimulus(ox[i], oy[i], 1'b0);
            tick(D + 6);
            ackPulse();
        end

        // Bouncing button never produces an event.
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            btn_raw = ~btn_raw;
            tick(1);
            seen |= pressed;
            tick(1);
            seen |= pressed;
        end
        btn_raw = 1'b0;
        tick(D + 6);
        checkOutput("bounce_no_event", 32'(seen | pressed | busy), 32'd0);

        // Randomized presses against the reference model.
        exp_x  = 576;
        exp_y  = 80;
        exp_id = 32'h0000_FFFF;
        for (int t = 0; t < 24; t++) begin
            int x, y;
            if ($urandom_range(1, 0) == 1) begin
                x = $urandom_range(575, 64);
                y = $urandom_range(431, 48);
            end else begin
                x = $urandom_range(1023, 0);
                y = $urandom_range(511, 0);
            end
            if ($urandom_range(3, 0) == 0) begin
                ackPulse();
                tick(2);
                checkOutput("rnd_idle_ack_pressed", 32'(pressed), 32'd0);
                checkOutput("rnd_idle_ack_x", 32'(x_game), 32'(exp_x));
            end
            applyStimulus(x, y, 1'b1);
            waitPressed(20, cyc);
            exp_x  = x;
            exp_y  = y;
            exp_id = modelId(x, y);
            checkOutput("rnd_pressed", 32'(pressed), 32'd1);
            checkOutput("rnd_x", 32'(x_game), 32'(exp_x));
            checkOutput("rnd_y", 32'(y_game), 32'(exp_y));
            checkOutput("rnd_id", VGAid, exp_id);
            applyStimulus($urandom_range(1023, 0), $urandom_range(511, 0), 1'b1);
            tick($urandom_range(5, 1));
            checkOutput("rnd_hold_id", VGAid, exp_id);
            if ($urandom_range(1, 0) == 1) begin
                btn_raw = 1'b0;
                tick(D + 6);
                ackPulse();
                checkOutput("rnd_ack_rel_pressed", 32'(pressed), 32'd0);
                checkOutput("rnd_ack_rel_busy", 32'(busy), 32'd0);
            end else begin
                ackPulse();
                checkOutput("rnd_ack_held_pressed", 32'(pressed), 32'd0);
                checkOutput("rnd_ack_held_busy", 32'(busy), 32'd1);
                btn_raw = 1'b0;
                waitIdle(20);
                checkOutput("rnd_release_busy", 32'(busy), 32'd0);
            end
            tick(2);
        end

        // Asynchronous reset during a pending event.
        applyStimulus(200, 100, 1'b1);
        waitPressed(20, cyc);
        checkOutput("prereset_pressed", 32'(pressed), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_pressed", 32'(pressed), 32'd0);
        checkOutput("async_x", 32'(x_game), 32'd0);
        checkOutput("async_y", 32'(y_game), 32'd0);
        checkOutput("async_id", VGAid, 32'd0);
        checkOutput("async_busy", 32'(busy), 32'd0);
        btn_raw = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(D + 8);
        checkOutput("post_reset_pressed", 32'(pressed), 32'd0);
        checkOutput("post_reset_busy", 32'(busy), 32'd0);

`ifdef FLAG_BUTTON_EN
        // Flag press alone.
        applyStimulus(100, 80, 1'b0);
        btn_flag_raw = 1'b1;
        waitPressed(20, cyc);
        checkOutput("flag_pressed", 32'(pressed), 32'd1);
        checkOutput("flag_id", VGAid, 32'h8000_0011);
        ackPulse();
        checkOutput("flag_ack_busy", 32'(busy), 32'd1);
        btn_flag_raw = 1'b0;
        waitIdle(20);
        checkOutput("flag_release_busy", 32'(busy), 32'd0);

        // Simultaneous select and flag: select wins.
        btn_raw      = 1'b1;
        btn_flag_raw = 1'b1;
        waitPressed(20, cyc);
        checkOutput("both_id", VGAid, 32'h0000_0011);
        ackPulse();
        btn_raw = 1'b0;
        tick(D + 6);
        checkOutput("both_flag_still_held", 32'(busy), 32'd1);
        btn_flag_raw = 1'b0;
        waitIdle(20);
        checkOutput("both_release_busy", 32'(busy), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
